pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Combines MEM-stage redirect
//  (branch/jump/jr), ID-stage load-use hazards and a fixed-latency multi-cycle EX op
//  (mul/div) into one registered FSM. Drives PC/IF_ID write enables, pipeline-register

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_perf_cnt.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   NPCOP_*      : NPCOp encodings seen in the MEM stage
//   hz_state_t   : sequencer state encoding
//   MD_CNT_W     : width of the mul/div occupancy counter
package pipeline_hazard_ctrl_pkg;

   localparam logic [2:0] NPCOP_SEQ = 3'b000;
   localparam logic [2:0] NPCOP_BEQ = 3'b001;
   localparam logic [2:0] NPCOP_J   = 3'b010;
   localparam logic [2:0] NPCOP_JR  = 3'b100;

   localparam int MD_CNT_W = 4;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MD_WAIT  = 2'd2
   } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: stall / redirect event counters for the hazard sequencer.
// Only present when STALL_CNT_EN is defined.
//   clk, rstn   : clock, asynchronous active-low reset
//   stall_inc   : count one stalled cycle (PC not written)
//   flush_inc   : count one redirect cycle
//   stall_cnt   : running stall count, wraps
//   flush_cnt   : running redirect count, wraps
`ifdef STALL_CNT_EN
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             stall_inc,
   input  logic             flush_inc,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Merges MEM-stage redirects, ID load-use hazards and fixed-latency mul/div
// occupancy of EX into one registered FSM with combinational outputs.
// Optional feature macro: STALL_CNT_EN (adds stall_cnt / flush_cnt outputs).
//   clk, rstn                   : clock, asynchronous active-low reset
//   id_rs/id_rt/id_use_rs/rt    : source operands of the ID instruction
//   ex_memread/ex_rd            : load in EX and its destination
//   ex_md_start                 : first EX cycle of a mul/div
//   mem_npcop/mem_zero          : control transfer resolved in MEM
//   npcop_out                   : qualified NPCOp to the NPC unit
//   pc_write/if_id_write/id_ex_write : pipeline register write enables
//   if_id_flush/id_ex_flush/ex_mem_flush : pipeline register clears
//   md_busy                     : mul/div still occupying EX
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = 8
`ifdef STALL_CNT_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rd,
   input  logic       ex_md_start,
   input  logic [2:0] mem_npcop,
   input  logic       mem_zero,
   output logic [2:0] npcop_out,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       id_ex_write,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_mem_flush,
   output logic       md_busy
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   // The start cycle is one EX cycle, and MD_WAIT runs counter values
   // MD_LAT-2 down to 0, giving MD_LAT EX cycles in total.
   localparam logic [MD_CNT_W-1:0] MD_INIT = MD_CNT_W'(MD_LAT - 2);

   hz_state_t           state, state_nxt;
   logic [MD_CNT_W-1:0] md_cnt, md_cnt_nxt;
   logic                redirect, loaduse, beq_taken;

   assign beq_taken = (mem_npcop == NPCOP_BEQ) && mem_zero;
   assign redirect  = beq_taken || (mem_npcop == NPCOP_J) || (mem_npcop == NPCOP_JR);
   assign loaduse   = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

   // An untaken beq becomes sequential; every other code passes straight through.
   assign npcop_out = ((mem_npcop == NPCOP_BEQ) && !mem_zero) ? NPCOP_SEQ : mem_npcop;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      md_busy      = 1'b0;
      state_nxt    = state;
      md_cnt_nxt   = md_cnt;
      if (redirect) begin
         // Younger instructions are all wrong-path: squash them, including
         // a mul/div or load-use stall in progress.
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         state_nxt    = RUN;
         md_cnt_nxt   = '0;
      end else begin
         unique case (state)
            RUN: begin
               if (ex_md_start) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_write  = 1'b0;
                  ex_mem_flush = 1'b1;
                  md_cnt_nxt   = MD_INIT;
                  state_nxt    = MD_WAIT;
               end else if (loaduse) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
                  state_nxt   = LU_STALL;
               end
            end
            // Load has moved to MEM; forwarding covers the dependency now.
            LU_STALL: state_nxt = RUN;
            MD_WAIT: begin
               md_busy = 1'b1;
               if (md_cnt == '0) begin
                  state_nxt = RUN;
               end else begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_write  = 1'b0;
                  ex_mem_flush = 1'b1;
                  md_cnt_nxt   = md_cnt - 1'b1;
               end
            end
            default: begin
               state_nxt  = RUN;
               md_cnt_nxt = '0;
            end
         endcase
      end
   end

`ifdef STALL_CNT_EN
   hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .stall_inc (!pc_write),
      .flush_inc (redirect),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (default build, MD_LAT=8).
// Output vector order: {npcop_out, pc_write, if_id_write, id_ex_write,
//                       if_id_flush, id_ex_flush, ex_mem_flush, md_busy}.
module tb_pipeline_hazard_ctrl;

   localparam int MD_LAT = 8;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic       id_use_rs, id_use_rt, ex_memread, ex_md_start, mem_zero;
   logic [2:0] mem_npcop;
   logic [2:0] npcop_out;
   logic       pc_write, if_id_write, id_ex_write;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, md_busy;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .ex_memread   (ex_memread),
      .ex_rd        (ex_rd),
      .ex_md_start  (ex_md_start),
      .mem_npcop    (mem_npcop),
      .mem_zero     (mem_zero),
      .npcop_out    (npcop_out),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .id_ex_write  (id_ex_write),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_flush (ex_mem_flush),
      .md_busy      (md_busy)
   );

   localparam logic [9:0] O_IDLE   = 10'b000_111_000_0;
   localparam logic [9:0] O_LU     = 10'b000_001_010_0;
   localparam logic [9:0] O_MDST   = 10'b000_000_001_0;
   localparam logic [9:0] O_MDWAIT = 10'b000_000_001_1;
   localparam logic [9:0] O_MDREL  = 10'b000_111_000_1;
   localparam logic [9:0] O_J      = 10'b010_111_111_0;

   typedef struct {
      string      name;
      logic [4:0] rs, rt, rd;
      logic       use_rs, use_rt, memread, md_start, zero;
      logic [2:0] npcop;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                               logic mr, logic [4:0] rd, logic md, logic [2:0] op, logic z,
                               logic [9:0] e);
      vec_t v;
      v.name = n; v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt;
      v.memread = mr; v.rd = rd; v.md_start = md; v.npcop = op; v.zero = z; v.exp = e;
      return v;
   endfunction

   function automatic logic [9:0] outs();
      return {npcop_out, pc_write, if_id_write, id_ex_write,
              if_id_flush, id_ex_flush, ex_mem_flush, md_busy};
   endfunction

   task automatic check(input string name, input logic [9:0] exp);
      logic [9:0] got;
      got = outs();
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mr, input logic [4:0] rd,
                        input logic md, input logic [2:0] op, input logic z);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      ex_memread = mr; ex_rd = rd; ex_md_start = md; mem_npcop = op; mem_zero = z;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);
   endtask

   // Called just after a posedge; leaves reset released before the next posedge.
   task automatic pulse_reset();
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
   endtask

   // Check at the negedge, then advance to just after the next posedge.
   task automatic cyc(input string name, input logic [9:0] exp);
      @(negedge clk);
      check(name, exp);
      @(posedge clk);
      #1;
   endtask

   // Reference model: remaining EX occupancy of a mul/div and a pending
   // load-use release cycle.
   int md_left = 0;
   bit lu_pend = 0;

   function automatic logic [9:0] model_out();
      logic [2:0] op;
      bit redir, lu;
      op = (mem_npcop == 3'b001 && !mem_zero) ? 3'b000 : mem_npcop;
      redir = (mem_npcop == 3'b001 && mem_zero) || mem_npcop == 3'b010 || mem_npcop == 3'b100;
      lu = ex_memread && ex_rd != 0 &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      if (redir)            return {op, 7'b111_111_0};
      if (md_left > 1)      return {op, 7'b000_001_1};
      if (md_left == 1)     return {op, 7'b111_000_1};
      if (lu_pend)          return {op, 7'b111_000_0};
      if (ex_md_start)      return {op, 7'b000_001_0};
      if (lu)               return {op, 7'b001_010_0};
      return {op, 7'b111_000_0};
   endfunction

   task automatic model_step();
      bit redir, lu;
      redir = (mem_npcop == 3'b001 && mem_zero) || mem_npcop == 3'b010 || mem_npcop == 3'b100;
      lu = ex_memread && ex_rd != 0 &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      if (redir) begin
         md_left = 0; lu_pend = 0;
      end else if (md_left > 0) begin
         md_left--;
      end else if (lu_pend) begin
         lu_pend = 0;
      end else if (ex_md_start) begin
         md_left = MD_LAT - 1;
      end else if (lu) begin
         lu_pend = 1;
      end
   endtask

   initial begin
      int busy_cnt;
      logic [2:0] op;
      idle();
      vecs[0]  = mk("idle",        0, 0, 0, 0, 0, 0, 0, 3'b000, 0, O_IDLE);
      vecs[1]  = mk("lu_rs",       1, 0, 1, 0, 1, 1, 0, 3'b000, 0, O_LU);
      vecs[2]  = mk("lu_rd0",      0, 0, 1, 1, 1, 0, 0, 3'b000, 0, O_IDLE);
      vecs[3]  = mk("lu_rt",       5, 2, 1, 1, 1, 2, 0, 3'b000, 0, O_LU);
      vecs[4]  = mk("lu_rt_unused",5, 2, 1, 0, 1, 2, 0, 3'b000, 0, O_IDLE);
      vecs[5]  = mk("no_load",     3, 3, 1, 1, 0, 3, 0, 3'b000, 0, O_IDLE);
      vecs[6]  = mk("beq_taken",   0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 10'b001_111_111_0);
      vecs[7]  = mk("beq_not",     0, 0, 0, 0, 0, 0, 0, 3'b001, 0, O_IDLE);
      vecs[8]  = mk("jump",        0, 0, 0, 0, 0, 0, 0, 3'b010, 0, O_J);
      vecs[9]  = mk("jr",          0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 10'b100_111_111_0);
      vecs[10] = mk("undef_011",   0, 0, 0, 0, 0, 0, 0, 3'b011, 1, 10'b011_111_000_0);
      vecs[11] = mk("md_start",    0, 0, 0, 0, 0, 0, 1, 3'b000, 0, O_MDST);
      vecs[12] = mk("md_and_lu",   4, 0, 1, 0, 1, 4, 1, 3'b000, 0, O_MDST);
      vecs[13] = mk("j_over_md",   0, 0, 0, 0, 0, 0, 1, 3'b010, 0, O_J);
      vecs[14] = mk("j_over_lu",   7, 0, 1, 0, 1, 7, 0, 3'b010, 1, O_J);
      vecs[15] = mk("undef_111",   0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 10'b111_111_000_0);

      // Reset state with idle inputs, checked while reset is still asserted.
      #1;
      check("reset_hold", O_IDLE);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      cyc("after_reset", O_IDLE);

      foreach (vecs[i]) begin
         pulse_reset();
         drive(vecs[i].rs, vecs[i].rt, vecs[i].use_rs, vecs[i].use_rt, vecs[i].memread,
               vecs[i].rd, vecs[i].md_start, vecs[i].npcop, vecs[i].zero);
         cyc(vecs[i].name, vecs[i].exp);
      end

      // Load-use: one stall cycle, one release cycle even with the hazard
      // inputs still present, then RUN sees it again.
      pulse_reset();
      drive(1, 0, 1, 0, 1, 1, 0, 3'b000, 0);
      cyc("lu_seq_stall", O_LU);
      cyc("lu_seq_release", O_IDLE);
      cyc("lu_seq_again", O_LU);

      // Mul/div: start cycle, six stalled waits, one release, back to RUN.
      pulse_reset();
      busy_cnt = 0;
      drive(0, 0, 0, 0, 0, 0, 1, 3'b000, 0);
      cyc("md_seq_start", O_MDST);
      idle();
      for (int k = 1; k <= MD_LAT - 2; k++) begin
         @(negedge clk);
         if (md_busy) busy_cnt++;
         check($sformatf("md_seq_wait%0d", k), O_MDWAIT);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      if (md_busy) busy_cnt++;
      check("md_seq_release", O_MDREL);
      @(posedge clk);
      #1;
      cyc("md_seq_run", O_IDLE);
      checks++;
      if (busy_cnt != MD_LAT - 1) begin
         errs++;
         $display("FAIL md_busy_len: got %0d expected %0d", busy_cnt, MD_LAT - 1);
      end

      // Redirect in the third MD_WAIT cycle aborts the mul/div.
      pulse_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 3'b000, 0);
      cyc("md_redir_start", O_MDST);
      idle();
      cyc("md_redir_w1", O_MDWAIT);
      cyc("md_redir_w2", O_MDWAIT);
      drive(0, 0, 0, 0, 0, 0, 0, 3'b010, 0);
      cyc("md_redir_jump", O_J);
      idle();
      cyc("md_redir_after", O_IDLE);

      // Asynchronous reset in the middle of MD_WAIT.
      pulse_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 3'b000, 0);
      cyc("md_rst_start", O_MDST);
      idle();
      cyc("md_rst_w1", O_MDWAIT);
      cyc("md_rst_w2", O_MDWAIT);
      #2;
      rstn = 1'b0;
      #1;
      check("md_rst_async", O_IDLE);
      #1;
      rstn = 1'b1;
      cyc("md_rst_after1", O_IDLE);
      cyc("md_rst_after2", O_IDLE);

      // Randomized traffic against the reference model.
      pulse_reset();
      md_left = 0; lu_pend = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            pulse_reset();
            md_left = 0; lu_pend = 0;
         end
         case ($urandom_range(0, 15))
            10, 11:  op = 3'b001;
            12:      op = 3'b010;
            13:      op = 3'b100;
            14:      op = 3'b011;
            15:      op = 3'($urandom_range(0, 7));
            default: op = 3'b000;
         endcase
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0), op, 1'($urandom_range(0, 1)));
         @(negedge clk);
         check($sformatf("rand%0d", n), model_out());
         model_step();
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
